bp_fe_mem_pipe: RTL and testbench



---
 rtl/bp_fe_pkg.sv | 45 ++++
 rtl/bp_fe_mem_pipe_fifo.sv | 56 +++++
 rtl/bp_fe_mem_pipe.sv | 143 ++++++++++++++
 tb/tb_bp_fe_mem_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_pkg.sv
// Shared types for the front-end fetch memory pipeline.
// Holds the command opcodes, privilege encodings, response layout and a safe clog2 helper.
// The response width macro keeps port declarations in step with the packed layout.
`ifndef BP_FE_PKG_SV
`define BP_FE_PKG_SV

`define BP_FE_MEM_PIPE_RESP_WIDTH(vaddr_width_mp, fetch_width_mp) ((vaddr_width_mp) + (fetch_width_mp) + 4)

package bp_fe_pkg;

  typedef enum logic [1:0] {
    e_fe_op_fetch     = 2'd0,
    e_fe_op_tlb_fill  = 2'd1,
    e_fe_op_tlb_fence = 2'd2
  } bp_fe_op_e;

  typedef enum logic [1:0] {
    e_priv_user       = 2'd0,
    e_priv_supervisor = 2'd1,
    e_priv_machine    = 2'd3
  } bp_priv_e;

  // Fault/miss flags in report-priority order, most significant first.
  typedef struct packed {
    logic itlb_miss;
    logic access_fault;
    logic page_fault;
    logic icache_miss;
  } bp_fe_mem_pipe_flags_s;

  // Response layout for the default configuration (39-bit vaddr, 32-bit fetch).
  typedef struct packed {
    logic [38:0]           vaddr;
    logic [31:0]           data;
    bp_fe_mem_pipe_flags_s flags;
  } bp_fe_mem_pipe_resp_s;

  // Pointer width that never collapses to zero bits for a 1-entry queue.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`endif

// File: rtl/bp_fe_mem_pipe_fifo.sv
// Response queue: els_p-deep two-pointer circular buffer with explicit count and clear.
// Latency: one cycle from enqueue to v_o; dequeue on yumi_i is visible next cycle.
// Backpressure: no full output; the producer guarantees a free slot through credits.
module bp_fe_mem_pipe_fifo
  import bp_fe_pkg::*;
#(
  parameter int els_p   = 4,
  parameter int width_p = 8,
  localparam int ptr_w_lp = safe_clog2(els_p),
  localparam int cnt_w_lp = $clog2(els_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                clear_i,
  input  logic                v_i,
  input  logic [width_p-1:0]  data_i,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  input  logic                yumi_i,
  output logic [cnt_w_lp-1:0] count_o
);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] rptr_r, wptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                deq;

  assign deq     = yumi_i & v_o;
  assign v_o     = (count_r != '0);
  assign data_o  = mem_r[rptr_r];
  assign count_o = count_r;

  // Storage array; written only, never reset.
  always_ff @(posedge clk_i) begin
    if (v_i) mem_r[wptr_r] <= data_i;
  end

  // Pointers wrap explicitly so non-power-of-two depths work; clear drops everything.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else if (clear_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (v_i) wptr_r <= (wptr_r == ptr_w_lp'(els_p - 1)) ? '0 : wptr_r + 1'b1;
      if (deq) rptr_r <= (rptr_r == ptr_w_lp'(els_p - 1)) ? '0 : rptr_r + 1'b1;
      if (v_i & ~deq)      count_r <= count_r + 1'b1;
      else if (~v_i & deq) count_r <= count_r - 1'b1;
    end
  end

endmodule

// File: rtl/bp_fe_mem_pipe.sv
// Front-end fetch pipeline: accept -> translate/check -> data, then a credited response queue.
// Latency: response valid three cycles after the fetch is accepted; one fetch per cycle sustained.
// Backpressure: cmd_ready_o drops when queued plus in-flight fetches would exceed queue depth.
module bp_fe_mem_pipe
  import bp_fe_pkg::*;
#(
  parameter int vaddr_width_p       = 39,
  parameter int ptag_width_p        = 28,
  parameter int page_offset_width_p = 12,
  parameter int fetch_width_p       = 32,
  parameter int resp_fifo_els_p     = 4,
  parameter int did_width_p         = 3,
  parameter logic [ptag_width_p-1:0] dram_base_ptag_p = 'h0080000,
  localparam int resp_width_lp = `BP_FE_MEM_PIPE_RESP_WIDTH(vaddr_width_p, fetch_width_p),
  localparam int cnt_w_lp      = $clog2(resp_fifo_els_p + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     cmd_v_i,
  output logic                     cmd_ready_o,
  input  logic [1:0]               cmd_op_i,
  input  logic [vaddr_width_p-1:0] cmd_vaddr_i,
  input  logic [1:0]               priv_i,
  input  logic                     translation_en_i,
  input  logic                     uncached_mode_i,
  output logic                     itlb_v_o,
  output logic                     itlb_w_o,
  output logic                     itlb_flush_o,
  input  logic                     itlb_v_i,
  input  logic                     itlb_miss_i,
  input  logic                     itlb_u_i,
  input  logic                     itlb_x_i,
  input  logic [ptag_width_p-1:0]  itlb_ptag_i,
  input  logic                     uncached_i,
  output logic                     icache_v_o,
  input  logic                     icache_ready_i,
  output logic                     icache_poison_o,
  input  logic [fetch_width_p-1:0] icache_data_i,
  input  logic                     icache_data_v_i,
  input  logic                     poison_i,
  input  logic                     flush_i,
  output logic                     resp_v_o,
  input  logic                     resp_ready_i,
  output logic [resp_width_lp-1:0] resp_o
);

  bp_fe_op_e cmd_op;
  logic ready_seen_r, s1_v_r, s2_v_r;
  logic [vaddr_width_p-1:0] s1_vaddr_r, s2_vaddr_r;
  logic s2_itlb_miss_r, s2_access_fault_r, s2_page_fault_r;
  logic [cnt_w_lp-1:0] fifo_count;
  logic [cnt_w_lp:0]   credits_used;
  logic fetch_ready, maint_ready, cmd_fire, fetch_acc, kill;
  logic access_fault, page_fault, s1_af, s1_pf, s1_any_fault;
  logic priv_u, priv_s, s2_icache_miss, enq;

  assign cmd_op = bp_fe_op_e'(cmd_op_i);
  assign kill   = poison_i | flush_i;

  // Every fetch in S1/S2 already owns a queue slot, so count it against the depth.
  assign credits_used = {1'b0, fifo_count} + (cnt_w_lp+1)'(s1_v_r) + (cnt_w_lp+1)'(s2_v_r);
  assign fetch_ready  = ready_seen_r & icache_ready_i & ~flush_i
                      & (credits_used < (cnt_w_lp+1)'(resp_fifo_els_p));
  // TLB maintenance must not reorder against translations still in flight.
  assign maint_ready  = ready_seen_r & ~flush_i & ~s1_v_r & ~s2_v_r;
  // Unknown opcodes are drained with maintenance ordering and have no side effect.
  assign cmd_ready_o  = (cmd_op == e_fe_op_fetch) ? fetch_ready : maint_ready;
  assign cmd_fire     = cmd_v_i & cmd_ready_o;
  assign fetch_acc    = cmd_fire & (cmd_op == e_fe_op_fetch);

  assign itlb_v_o     = fetch_acc;
  assign icache_v_o   = fetch_acc;
  assign itlb_w_o     = cmd_fire & (cmd_op == e_fe_op_tlb_fill);
  assign itlb_flush_o = cmd_fire & (cmd_op == e_fe_op_tlb_fence);

  // S1 checks: PMA/DID/DRAM-range access rules and U/S/X permission rules.
  assign priv_u       = (priv_i == e_priv_user);
  assign priv_s       = (priv_i == e_priv_supervisor);
  assign access_fault = (uncached_mode_i & ~uncached_i)
                      | (|itlb_ptag_i[ptag_width_p-1 -: did_width_p])
                      | (itlb_ptag_i < dram_base_ptag_p);
  assign page_fault   = translation_en_i & itlb_v_i
                      & ((priv_s & itlb_u_i) | (priv_u & ~itlb_u_i) | ~itlb_x_i);
  assign s1_af        = ~itlb_miss_i & access_fault;
  assign s1_pf        = ~itlb_miss_i & ~access_fault & page_fault;
  assign s1_any_fault = itlb_miss_i | access_fault | page_fault;

  // The I-cache must drop the data access for anything that will not be reported as a hit.
  assign icache_poison_o = kill | (s1_v_r & s1_any_fault);

  assign s2_icache_miss = ~icache_data_v_i
                        & ~(s2_itlb_miss_r | s2_access_fault_r | s2_page_fault_r);
  assign enq            = s2_v_r & ~kill;

  // Stage valids; a fetch accepted in a poison cycle survives since poison hits S1/S2 only.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ready_seen_r <= 1'b0;
      s1_v_r       <= 1'b0;
      s2_v_r       <= 1'b0;
    end else begin
      ready_seen_r <= ready_seen_r | icache_ready_i;
      s1_v_r       <= fetch_acc;
      s2_v_r       <= s1_v_r & ~kill;
    end
  end

  // Stage payloads; flags are stored already priority-masked.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_vaddr_r        <= '0;
      s2_vaddr_r        <= '0;
      s2_itlb_miss_r    <= 1'b0;
      s2_access_fault_r <= 1'b0;
      s2_page_fault_r   <= 1'b0;
    end else begin
      if (fetch_acc) s1_vaddr_r <= cmd_vaddr_i;
      if (s1_v_r) begin
        s2_vaddr_r        <= s1_vaddr_r;
        s2_itlb_miss_r    <= itlb_miss_i;
        s2_access_fault_r <= s1_af;
        s2_page_fault_r   <= s1_pf;
      end
    end
  end

  bp_fe_mem_pipe_fifo #(
    .els_p   (resp_fifo_els_p),
    .width_p (resp_width_lp)
  ) resp_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (flush_i),
    .v_i       (enq),
    .data_i    ({s2_vaddr_r, icache_data_i, s2_itlb_miss_r, s2_access_fault_r,
                 s2_page_fault_r, s2_icache_miss}),
    .v_o       (resp_v_o),
    .data_o    (resp_o),
    .yumi_i    (resp_ready_i),
    .count_o   (fifo_count)
  );

endmodule

// File: tb/tb_bp_fe_mem_pipe.sv
// Directed bench for bp_fe_mem_pipe with default parameters.
// A small I-cache model returns vaddr[31:0]^A5A50000 two cycles after each access.
// Expected responses are built from the issued vaddr and hand-derived flag values.
module tb_bp_fe_mem_pipe;
  import bp_fe_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        cmd_v_i, cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [38:0] cmd_vaddr_i;
  logic [1:0]  priv_i;
  logic        translation_en_i, uncached_mode_i;
  logic        itlb_v_o, itlb_w_o, itlb_flush_o;
  logic        itlb_v_i, itlb_miss_i, itlb_u_i, itlb_x_i;
  logic [27:0] itlb_ptag_i;
  logic        uncached_i;
  logic        icache_v_o, icache_ready_i, icache_poison_o;
  logic [31:0] icache_data_i;
  logic        icache_data_v_i;
  logic        poison_i, flush_i;
  logic        resp_v_o, resp_ready_i;
  logic [74:0] resp_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [38:0] ic_a1 = '0, ic_a2 = '0;

  always #5 clk = ~clk;

  // I-cache data model: two-cycle pipe of the requested vaddr.
  always @(posedge clk) begin
    ic_a1 <= cmd_vaddr_i;
    ic_a2 <= ic_a1;
  end
  assign icache_data_i = ic_a2[31:0] ^ 32'hA5A5_0000;

  bp_fe_mem_pipe dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i), .cmd_vaddr_i(cmd_vaddr_i),
    .priv_i(priv_i), .translation_en_i(translation_en_i), .uncached_mode_i(uncached_mode_i),
    .itlb_v_o(itlb_v_o), .itlb_w_o(itlb_w_o), .itlb_flush_o(itlb_flush_o),
    .itlb_v_i(itlb_v_i), .itlb_miss_i(itlb_miss_i), .itlb_u_i(itlb_u_i), .itlb_x_i(itlb_x_i),
    .itlb_ptag_i(itlb_ptag_i), .uncached_i(uncached_i),
    .icache_v_o(icache_v_o), .icache_ready_i(icache_ready_i), .icache_poison_o(icache_poison_o),
    .icache_data_i(icache_data_i), .icache_data_v_i(icache_data_v_i),
    .poison_i(poison_i), .flush_i(flush_i),
    .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i), .resp_o(resp_o)
  );

  function automatic logic [74:0] mk(input logic [38:0] va, input logic [3:0] fl);
    return {va, va[31:0] ^ 32'hA5A5_0000, fl};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single fetch: reports S1 poison and the response seen three cycles after accept.
  task automatic run_one(input logic [38:0] va, output logic pois, output logic rv,
                         output logic [74:0] r);
    cmd_op_i = e_fe_op_fetch; cmd_v_i = 1'b1; cmd_vaddr_i = va;
    tick();
    cmd_v_i = 1'b0;
    pois = icache_poison_o;
    tick();
    tick();
    rv = resp_v_o; r = resp_o;
    tick();
  endtask

  // Offer fetches for n cycles, advancing vaddr only on acceptance.
  task automatic try_fetches(input int n, input logic [38:0] base, output int acc,
                             output logic last_rdy);
    acc = 0; last_rdy = 1'b0;
    cmd_op_i = e_fe_op_fetch;
    for (int i = 0; i < n; i++) begin
      cmd_v_i = 1'b1; cmd_vaddr_i = base + 39'(4 * acc);
      #1;
      last_rdy = cmd_ready_o;
      if (cmd_ready_o) acc++;
      tick();
    end
    cmd_v_i = 1'b0;
  endtask

  logic        pois, rv, rdy;
  logic [74:0] r;
  int          acc;
  logic [38:0] va;

  initial begin
    reset_n_i = 1'b0; cmd_v_i = 1'b0; cmd_op_i = e_fe_op_fetch; cmd_vaddr_i = '0;
    priv_i = e_priv_supervisor; translation_en_i = 1'b1; uncached_mode_i = 1'b0;
    itlb_v_i = 1'b1; itlb_miss_i = 1'b0; itlb_u_i = 1'b0; itlb_x_i = 1'b1;
    itlb_ptag_i = 28'h0080010; uncached_i = 1'b0; icache_ready_i = 1'b0;
    icache_data_v_i = 1'b1; poison_i = 1'b0; flush_i = 1'b0; resp_ready_i = 1'b1;

    // Reset state
    #12;
    chk("rst_resp_v", resp_v_o, 0);
    chk("rst_cmd_ready", cmd_ready_o, 0);
    chk("rst_icache_v", icache_v_o, 0);
    icache_ready_i = 1'b1;
    @(negedge clk); reset_n_i = 1'b1; #1;
    chk("ready_before_sample", cmd_ready_o, 0);
    tick();
    chk("ready_after_sample", cmd_ready_o, 1);

    // 8 back-to-back fetches, one response per cycle starting at t+3
    for (int c = 0; c < 11; c++) begin
      cmd_v_i = (c < 8); cmd_vaddr_i = 39'h80000000 + 39'(4 * c);
      tick();
      if (c == 1) chk("b2b_not_early", resp_v_o, 0);
      if (c >= 2 && c <= 9) begin
        chk("b2b_resp_v", resp_v_o, 1);
        chk("b2b_resp", resp_o, mk(39'h80000000 + 39'(4 * (c - 2)), 4'b0000));
      end
    end
    chk("b2b_drained", resp_v_o, 0);

    // Backpressure: only the queue depth worth of fetches is accepted
    resp_ready_i = 1'b0;
    try_fetches(6, 39'h80001000, acc, rdy);
    chk("bp_accepted", acc, 4);
    chk("bp_last_ready", rdy, 0);
    chk("bp_full_ready", cmd_ready_o, 0);
    resp_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_drain_v", resp_v_o, 1);
      chk("bp_drain_resp", resp_o, mk(39'h80001000 + 39'(4 * k), 4'b0000));
      tick();
    end
    chk("bp_empty", resp_v_o, 0);

    // Fault classification
    itlb_ptag_i = 28'h0000010;
    run_one(39'h80002000, pois, rv, r);
    chk("af_poison", pois, 1); chk("af_v", rv, 1); chk("af_resp", r, mk(39'h80002000, 4'b0100));
    itlb_ptag_i = 28'h0080010; priv_i = e_priv_user;
    run_one(39'h80002004, pois, rv, r);
    chk("pf_poison", pois, 1); chk("pf_resp", r, mk(39'h80002004, 4'b0010));
    itlb_ptag_i = 28'h0000010;
    run_one(39'h80002008, pois, rv, r);
    chk("af_pf_resp", r, mk(39'h80002008, 4'b0100));
    itlb_miss_i = 1'b1;
    run_one(39'h8000200C, pois, rv, r);
    chk("miss_poison", pois, 1); chk("miss_resp", r, mk(39'h8000200C, 4'b1000));
    itlb_miss_i = 1'b0; priv_i = e_priv_supervisor; itlb_ptag_i = 28'h2080010;
    run_one(39'h80002010, pois, rv, r);
    chk("did_resp", r, mk(39'h80002010, 4'b0100));
    itlb_ptag_i = 28'h0080010; uncached_mode_i = 1'b1;
    run_one(39'h80002014, pois, rv, r);
    chk("uc_mode_resp", r, mk(39'h80002014, 4'b0100));
    uncached_mode_i = 1'b0; icache_data_v_i = 1'b0;
    run_one(39'h80002018, pois, rv, r);
    chk("icm_poison", pois, 0); chk("icm_resp", r, mk(39'h80002018, 4'b0001));
    icache_data_v_i = 1'b1;

    // Poison kills A in S1 while B, accepted the same cycle, survives
    cmd_v_i = 1'b1; cmd_vaddr_i = 39'h80003000;
    tick();
    poison_i = 1'b1; cmd_vaddr_i = 39'h80003004;
    #1;
    chk("poison_out", icache_poison_o, 1);
    tick();
    poison_i = 1'b0; cmd_v_i = 1'b0;
    tick();
    chk("poison_no_a", resp_v_o, 0);
    tick();
    chk("poison_b_v", resp_v_o, 1);
    chk("poison_b_resp", resp_o, mk(39'h80003004, 4'b0000));
    tick();
    chk("poison_done", resp_v_o, 0);

    // Flush with three queued entries restores all credits
    resp_ready_i = 1'b0;
    try_fetches(3, 39'h80004000, acc, rdy);
    tick(); tick();
    chk("flush_pre_v", resp_v_o, 1);
    flush_i = 1'b1;
    #1;
    chk("flush_ready_low", cmd_ready_o, 0);
    tick();
    flush_i = 1'b0;
    chk("flush_resp_v", resp_v_o, 0);
    try_fetches(6, 39'h80005000, acc, rdy);
    chk("flush_credits", acc, 4);
    resp_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk("flush_drained", resp_v_o, 0);

    // Fence waits for an empty pipe, strobes once, makes no response
    cmd_v_i = 1'b1; cmd_op_i = e_fe_op_fetch; cmd_vaddr_i = 39'h80006000;
    tick();
    cmd_op_i = e_fe_op_tlb_fence;
    #1;
    chk("fence_hold_s1", cmd_ready_o, 0);
    chk("fence_no_strobe", itlb_flush_o, 0);
    tick();
    chk("fence_hold_s2", cmd_ready_o, 0);
    tick();
    chk("fence_ready", cmd_ready_o, 1);
    chk("fence_strobe", itlb_flush_o, 1);
    chk("fence_fetch_resp", resp_o, mk(39'h80006000, 4'b0000));
    tick();
    cmd_v_i = 1'b0; cmd_op_i = e_fe_op_fetch;
    #1;
    chk("fence_strobe_off", itlb_flush_o, 0);
    chk("fence_no_resp", resp_v_o, 0);
    cmd_v_i = 1'b1; cmd_op_i = e_fe_op_tlb_fill;
    #1;
    chk("fill_strobe", itlb_w_o, 1);
    chk("fill_no_itlb_v", itlb_v_o, 0);
    tick();
    cmd_v_i = 1'b0; cmd_op_i = e_fe_op_fetch;
    tick(); tick();
    chk("fill_no_resp", resp_v_o, 0);

    // Async reset with a fetch in S1: nothing comes out afterwards
    cmd_v_i = 1'b1; cmd_vaddr_i = 39'h80007000;
    tick();
    cmd_v_i = 1'b0;
    #2 reset_n_i = 1'b0;
    #1;
    chk("arst_ready", cmd_ready_o, 0);
    chk("arst_poison", icache_poison_o, 0);
    tick();
    reset_n_i = 1'b1;
    tick(); tick(); tick();
    chk("arst_no_resp", resp_v_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
